// File: rtl/ramrom_arbiter.sv
// ramrom_arbiter
// Arbitrates the single-ported RamRom block RAM between the CPU bus and the
// video fetch unit. One access is granted per cycle. Video wins ties, but only
// MAX_STREAK times in a row while the CPU is waiting. Writes below ROM_TOP are
// acknowledged and dropped. Read data returns to its owner two edges after the
// transfer edge.
//
// Ports:
//   clk_sys, reset_n          system clock, async active-low reset
//   cpu_req/we/addr/be/wdata  CPU request (held until cpu_ack)
//   cpu_ack                   combinational grant; transfer on req & ack
//   cpu_rvalid/rdata          CPU read return strobe and data
//   vid_req/addr              video read request
//   vid_ack                   combinational grant
//   vid_rvalid/rdata          video read return strobe and data
//   ram_addr/byteena/data/wren/clken  registered RAM controls
//   ram_q                     RAM read data, one cycle after address sample
//   wr_blocked                one-cycle pulse when a ROM-region write is dropped
module ramrom_arbiter #(
    parameter int unsigned    AW         = 18,
    parameter int unsigned    DW         = 16,
    parameter logic [AW-1:0]  ROM_TOP    = 18'h04000,
    parameter int unsigned    MAX_STREAK = 4
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW/8-1:0]   cpu_be,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DW-1:0]     cpu_rdata,
    input  logic              vid_req,
    input  logic [AW-1:0]     vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [DW-1:0]     vid_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic [DW/8-1:0]   ram_byteena,
    output logic [DW-1:0]     ram_data,
    output logic              ram_wren,
    output logic              ram_clken,
    input  logic [DW-1:0]     ram_q,
    output logic              wr_blocked
);

    localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);

    logic [3:0]      streak_q, streak_d;
    logic            at_limit, cpu_rom;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW/8-1:0] be_q, be_d;
    logic [DW-1:0]   data_q, data_d;
    logic            wren_q, wren_d;
    logic            blocked_q, blocked_d;
    logic            clken_q;
    // Tag pipeline: stage 1 follows the RAM address, stage 2 follows ram_q.
    logic            tag1_vld_q, tag1_vld_d, tag1_cpu_q, tag1_cpu_d;
    logic            tag2_vld_q, tag2_cpu_q;
    logic            cpu_rvalid_q, cpu_rvalid_d, vid_rvalid_q, vid_rvalid_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;

    // Grants depend only on the requests and the streak counter.
    assign at_limit = (streak_q == STREAK_LIM);
    assign cpu_ack  = cpu_req & (~vid_req | at_limit);
    assign vid_ack  = vid_req & ~(cpu_req & at_limit);
    assign cpu_rom  = (cpu_addr < ROM_TOP);

    always_comb begin
        streak_d = streak_q;
        if (!cpu_req || cpu_ack) begin
            streak_d = '0;
        end else if (vid_ack && !at_limit) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Issue stage: address/enables/data hold when idle, write enable does not.
    always_comb begin
        addr_d     = addr_q;
        be_d       = be_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        blocked_d  = 1'b0;
        tag1_vld_d = 1'b0;
        tag1_cpu_d = 1'b0;
        if (vid_ack) begin
            addr_d     = vid_addr;
            be_d       = '1;
            tag1_vld_d = 1'b1;
        end else if (cpu_ack) begin
            addr_d = cpu_addr;
            if (!cpu_we) begin
                be_d       = '1;
                tag1_vld_d = 1'b1;
                tag1_cpu_d = 1'b1;
            end else if (cpu_rom) begin
                blocked_d = 1'b1;
            end else begin
                wren_d = 1'b1;
                be_d   = cpu_be;
                data_d = cpu_wdata;
            end
        end
    end

    always_comb begin
        cpu_rvalid_d = tag2_vld_q & tag2_cpu_q;
        vid_rvalid_d = tag2_vld_q & ~tag2_cpu_q;
        cpu_rdata_d  = cpu_rvalid_d ? ram_q : cpu_rdata_q;
        vid_rdata_d  = vid_rvalid_d ? ram_q : vid_rdata_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            streak_q     <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            data_q       <= '0;
            wren_q       <= 1'b0;
            blocked_q    <= 1'b0;
            clken_q      <= 1'b0;
            tag1_vld_q   <= 1'b0;
            tag1_cpu_q   <= 1'b0;
            tag2_vld_q   <= 1'b0;
            tag2_cpu_q   <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
        end else begin
            streak_q     <= streak_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            blocked_q    <= blocked_d;
            clken_q      <= 1'b1;
            tag1_vld_q   <= tag1_vld_d;
            tag1_cpu_q   <= tag1_cpu_d;
            tag2_vld_q   <= tag1_vld_q;
            tag2_cpu_q   <= tag1_cpu_q;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rdata_q  <= vid_rdata_d;
        end
    end

    assign ram_addr    = addr_q;
    assign ram_byteena = be_q;
    assign ram_data    = data_q;
    assign ram_wren    = wren_q;
    assign ram_clken   = clken_q;
    assign wr_blocked  = blocked_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign vid_rvalid  = vid_rvalid_q;
    assign vid_rdata   = vid_rdata_q;

endmodule

// File: tb/tb_ramrom_arbiter.sv
module tb_ramrom_arbiter;

    localparam int          MAX_STREAK = 4;
    localparam logic [17:0] ROM_TOP    = 18'h04000;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [17:0] cpu_addr;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_wdata;
    logic        cpu_ack, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vid_req;
    logic [17:0] vid_addr;
    logic        vid_ack, vid_rvalid;
    logic [15:0] vid_rdata;
    logic [17:0] ram_addr;
    logic [1:0]  ram_byteena;
    logic [15:0] ram_data;
    logic        ram_wren, ram_clken;
    logic [15:0] ram_q;
    logic        wr_blocked;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    ramrom_arbiter #(
        .AW(18), .DW(16), .ROM_TOP(ROM_TOP), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .ram_addr(ram_addr), .ram_byteena(ram_byteena), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_clken(ram_clken), .ram_q(ram_q),
        .wr_blocked(wr_blocked)
    );

    function automatic logic [15:0] init_word(input logic [17:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0] = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    // Block RAM environment model: registered output, read-before-write.
    logic [15:0] ram_mem [int];
    logic [15:0] ram_w;
    function automatic logic [15:0] ram_rd(input logic [17:0] a);
        return ram_mem.exists(int'(a)) ? ram_mem[int'(a)] : init_word(a);
    endfunction
    always @(posedge clk_sys) begin
        if (ram_clken) begin
            ram_q <= ram_rd(ram_addr);
            if (ram_wren) begin
                ram_w = merge(ram_rd(ram_addr), ram_data, ram_byteena);
                ram_mem[int'(ram_addr)] = ram_w;
            end
        end
    end

    // Reference model: expected memory contents, pending reads, CPU wait count.
    typedef struct {
        int          due;
        bit          is_cpu;
        logic [15:0] data;
    } rd_t;
    rd_t         rdq[$];
    rd_t         r;
    logic [15:0] shadow [int];
    int          cyc = 0;
    int          m_wait = 0;
    logic        g_cpu, g_vid, x_cv, x_vv;
    logic [17:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_data, e_crd, e_vrd;
    logic        e_wren, e_blk, e_clken, e_be_chk;

    function automatic logic [15:0] shadow_rd(input logic [17:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
    endfunction

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            total++;
            if ({ram_addr, ram_byteena, ram_data, ram_wren, ram_clken, cpu_rvalid, vid_rvalid,
                 cpu_rdata, vid_rdata, wr_blocked} !== '0) begin
                bad++;
                $display("FAIL mon_reset: got addr=%h be=%b data=%h wren=%b clken=%b rv=%b%b blk=%b want all zero",
                         ram_addr, ram_byteena, ram_data, ram_wren, ram_clken, cpu_rvalid,
                         vid_rvalid, wr_blocked);
            end
            rdq.delete();
            m_wait = 0;
            e_addr = '0; e_be = '0; e_data = '0; e_wren = 0; e_blk = 0; e_clken = 0;
            e_crd = '0; e_vrd = '0; e_be_chk = 1;
        end else begin
            cyc++;
            total++;
            if (ram_wren !== e_wren || wr_blocked !== e_blk || ram_addr !== e_addr
                || ram_clken !== e_clken) begin
                bad++;
                $display("FAIL mon_issue @%0d: got wren=%b blk=%b addr=%h clken=%b want %b %b %h %b",
                         cyc, ram_wren, wr_blocked, ram_addr, ram_clken, e_wren, e_blk, e_addr,
                         e_clken);
            end
            total++;
            if ((e_be_chk && ram_byteena !== e_be) || (e_wren && ram_data !== e_data)) begin
                bad++;
                $display("FAIL mon_wdata @%0d: got be=%b data=%h want be=%b data=%h",
                         cyc, ram_byteena, ram_data, e_be, e_data);
            end
            x_cv = 0;
            x_vv = 0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                if (r.is_cpu) begin x_cv = 1; e_crd = r.data; end
                else begin x_vv = 1; e_vrd = r.data; end
            end
            total++;
            if (cpu_rvalid !== x_cv || vid_rvalid !== x_vv || cpu_rdata !== e_crd
                || vid_rdata !== e_vrd) begin
                bad++;
                $display("FAIL mon_return @%0d: got rv=%b%b cd=%h vd=%h want rv=%b%b cd=%h vd=%h",
                         cyc, cpu_rvalid, vid_rvalid, cpu_rdata, vid_rdata, x_cv, x_vv,
                         e_crd, e_vrd);
            end
            // CPU wins a tie only after MAX_STREAK consecutive video wins.
            g_cpu = cpu_req && (!vid_req || m_wait == MAX_STREAK);
            g_vid = vid_req && !g_cpu;
            total++;
            if (cpu_ack !== g_cpu || vid_ack !== g_vid) begin
                bad++;
                $display("FAIL mon_grant @%0d: got ack=%b%b want %b%b",
                         cyc, cpu_ack, vid_ack, g_cpu, g_vid);
            end
            e_wren = 0;
            e_blk = 0;
            e_clken = 1;
            if (g_vid) begin
                e_addr = vid_addr; e_be = 2'b11; e_be_chk = 1;
                rdq.push_back('{due: cyc + 3, is_cpu: 1'b0, data: shadow_rd(vid_addr)});
            end else if (g_cpu) begin
                e_addr = cpu_addr;
                if (!cpu_we) begin
                    e_be_chk = 0;
                    rdq.push_back('{due: cyc + 3, is_cpu: 1'b1, data: shadow_rd(cpu_addr)});
                end else if (cpu_addr >= ROM_TOP) begin
                    e_wren = 1; e_be = cpu_be; e_data = cpu_wdata; e_be_chk = 1;
                    shadow[int'(cpu_addr)] = merge(shadow_rd(cpu_addr), cpu_wdata, cpu_be);
                end else begin
                    e_blk = 1;
                end
            end
            m_wait = (cpu_req && g_vid) ? m_wait + 1 : 0;
        end
    end

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        vid_req = 0; vid_addr = '0;
    endtask

    task automatic cpu_drive(input logic we, input logic [17:0] a, input logic [15:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_be = 2'b11; cpu_wdata = d;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        cpu_req = 1;
        vid_req = 1;
        repeat (3) begin
            @(negedge clk_sys);
            total++;
            if ({ram_addr, ram_byteena, ram_data, ram_wren, ram_clken, cpu_rvalid,
                 vid_rvalid} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got addr=%h wren=%b clken=%b want 0",
                         ram_addr, ram_wren, ram_clken);
            end
        end
        @(posedge clk_sys); #1;
        reset_n = 1;
        idle_inputs();
        @(negedge clk_sys);
        total++;
        if (ram_clken !== 1'b0) begin
            bad++; $display("FAIL clken_before_edge: got %b want 0", ram_clken);
        end
        @(negedge clk_sys);
        total++;
        if (ram_clken !== 1'b1) begin
            bad++; $display("FAIL clken_after_edge: got %b want 1", ram_clken);
        end
    endtask

    task automatic test_cpu_write_read();
        @(posedge clk_sys); #1;
        cpu_drive(1, 18'h04010, 16'hBEEF);
        @(negedge clk_sys);
        total++;
        if (cpu_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", cpu_ack); end
        @(posedge clk_sys); #1;
        cpu_drive(0, 18'h04010, 16'h0000);
        @(negedge clk_sys);
        total++;
        if (ram_wren !== 1'b1 || ram_data !== 16'hBEEF || ram_addr !== 18'h04010) begin
            bad++;
            $display("FAIL wr_issue: got wren=%b data=%h addr=%h want 1 beef 04010",
                     ram_wren, ram_data, ram_addr);
        end
        @(posedge clk_sys); #1;
        idle_inputs();
        @(negedge clk_sys);
        total++;
        if (ram_wren !== 1'b0) begin bad++; $display("FAIL wr_one_cycle: got %b want 0", ram_wren); end
        @(negedge clk_sys);
        total++;
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early: got %b want 0", cpu_rvalid); end
        @(negedge clk_sys);
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL rd_back: got rv=%b data=%h want 1 beef", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_rom_protect();
        @(posedge clk_sys); #1;
        cpu_drive(1, 18'h00100, 16'h1234);
        @(negedge clk_sys);
        total++;
        if (cpu_ack !== 1'b1) begin bad++; $display("FAIL rom_ack: got %b want 1", cpu_ack); end
        @(posedge clk_sys); #1;
        cpu_drive(0, 18'h00100, 16'h0000);
        @(negedge clk_sys);
        total++;
        if (ram_wren !== 1'b0 || wr_blocked !== 1'b1) begin
            bad++;
            $display("FAIL rom_block: got wren=%b blk=%b want 0 1", ram_wren, wr_blocked);
        end
        @(posedge clk_sys); #1;
        idle_inputs();
        @(negedge clk_sys);
        total++;
        if (wr_blocked !== 1'b0) begin bad++; $display("FAIL rom_pulse: got %b want 0", wr_blocked); end
        @(negedge clk_sys);
        @(negedge clk_sys);
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== init_word(18'h00100)) begin
            bad++;
            $display("FAIL rom_orig: got rv=%b data=%h want 1 %h",
                     cpu_rvalid, cpu_rdata, init_word(18'h00100));
        end
    endtask

    task automatic test_starvation();
        logic exp_cpu;
        @(posedge clk_sys); #1;
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_sys); #1;
            cpu_drive(0, 18'h04020, 16'h0000);
            vid_req = 1;
            vid_addr = 18'(i);
            @(negedge clk_sys);
            exp_cpu = (i % 5 == 4);
            total++;
            if (cpu_ack !== exp_cpu || vid_ack !== !exp_cpu) begin
                bad++;
                $display("FAIL starve_pattern[%0d]: got ack=%b%b want %b%b",
                         i, cpu_ack, vid_ack, exp_cpu, !exp_cpu);
            end
        end
        @(posedge clk_sys); #1;
        idle_inputs();
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_video_stream();
        logic exp_v;
        for (int k = 0; k < 11; k++) begin
            @(posedge clk_sys); #1;
            idle_inputs();
            vid_req = (k < 8);
            vid_addr = 18'(k);
            @(negedge clk_sys);
            exp_v = (k >= 3 && k <= 10);
            total++;
            if (vid_rvalid !== exp_v || (exp_v && vid_rdata !== init_word(18'(k - 3)))) begin
                bad++;
                $display("FAIL vid_stream[%0d]: got rv=%b data=%h want %b %h",
                         k, vid_rvalid, vid_rdata, exp_v, init_word(18'(k - 3)));
            end
        end
    endtask

    task automatic test_random();
        logic cpu_taken;
        cpu_taken = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk_sys); #1;
            if (!cpu_req || cpu_taken) begin
                cpu_req = ($urandom_range(0, 2) != 0);
                cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = 18'h03FF0 + 18'($urandom_range(0, 31));
                cpu_be = 2'($urandom_range(0, 3));
                cpu_wdata = 16'($urandom);
            end
            vid_req = $urandom_range(0, 1) == 1;
            vid_addr = 18'h03FF0 + 18'($urandom_range(0, 31));
            @(negedge clk_sys);
            cpu_taken = cpu_req && cpu_ack;
            total++;
            if ((cpu_ack && vid_ack) || (cpu_ack && !cpu_req) || (vid_ack && !vid_req)) begin
                bad++;
                $display("FAIL rand_exclusive[%0d]: got ack=%b%b req=%b%b",
                         i, cpu_ack, vid_ack, cpu_req, vid_req);
            end
        end
        @(posedge clk_sys); #1;
        idle_inputs();
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk_sys); #1;
        cpu_drive(0, 18'h04010, 16'h0000);
        @(negedge clk_sys);
        total++;
        if (cpu_ack !== 1'b1) begin bad++; $display("FAIL mid_ack: got %b want 1", cpu_ack); end
        @(posedge clk_sys); #1;
        idle_inputs();
        @(posedge clk_sys); #1;
        reset_n = 0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_sys);
            total++;
            if (cpu_rvalid !== 1'b0) begin
                bad++; $display("FAIL mid_no_rvalid[%0d]: got %b want 0", k, cpu_rvalid);
            end
        end
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_cpu_write_read();
        test_rom_protect();
        test_starvation();
        test_video_stream();
        test_random();
        test_reset_mid_read();
        test_cpu_write_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
